// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command bridge: opcodes, FSM states,
// status-word bit offsets and the error response.
package spi_cmd_pkg;

  localparam int WORD_W_DEF  = 16;
  localparam int LEVEL_W_DEF = 12;
  localparam int CTRL_W_DEF  = 8;
  localparam int OPCODE_W    = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP         = 4'h0,
    OP_READ_SAMPLE = 4'h1,
    OP_READ_STATUS = 4'h2,
    OP_WRITE_CTRL  = 4'h3,
    OP_CLEAR_FLAGS = 4'h4
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_FETCH,
    ST_LOAD
  } state_e;

  // Status bits are placed relative to the MSB so they track any word width.
  localparam int STAT_OVF_OFS   = 1;
  localparam int STAT_UDF_OFS   = 2;
  localparam int STAT_DROP_OFS  = 3;
  localparam int STAT_CAPEN_OFS = 4;

  // Wide enough for any supported word width; sliced down at the use site.
  localparam logic [63:0] ERR_RESP = '1;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic drop;
  } flags_t;

endpackage

// File: rtl/spi_cmd_bridge_if.sv
// Word-level bus between the command bridge, the SPI slave and the sample FIFO.
// master = the bridge side, slave = the SPI slave / FIFO side.
interface spi_cmd_bridge_if #(
  parameter int WORD_W  = 16,
  parameter int LEVEL_W = 12,
  parameter int CTRL_W  = 8
);
  logic [WORD_W-1:0]  rx_data;
  logic               rx_valid;
  logic               spi_idle;
  logic [WORD_W-1:0]  tx_data;
  logic               tx_valid;
  logic [WORD_W-1:0]  fifo_rd_data;
  logic               fifo_empty;
  logic [LEVEL_W-1:0] fifo_level;
  logic               fifo_overflow;
  logic               fifo_rd_en;
  logic [CTRL_W-1:0]  ctrl;
  logic               ctrl_wr;

  modport master (
    input  rx_data, rx_valid, spi_idle, fifo_rd_data, fifo_empty, fifo_level, fifo_overflow,
    output tx_data, tx_valid, fifo_rd_en, ctrl, ctrl_wr
  );

  modport slave (
    output rx_data, rx_valid, spi_idle, fifo_rd_data, fifo_empty, fifo_level, fifo_overflow,
    input  tx_data, tx_valid, fifo_rd_en, ctrl, ctrl_wr
  );
endinterface

// File: rtl/sticky_flags.sv
// Three sticky status flags with a shared clear; a set in the same cycle as a
// clear wins.
module sticky_flags
  import spi_cmd_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  flags_t i_set,
  input  logic   i_clr,
  output flags_t o_flags
);
  flags_t r_flags;

  // NOTE: sequential state uses <= so every flop samples pre-edge values,
  // independent of process ordering in simulation.
  always_ff @(posedge clk) begin
    if (rst) r_flags <= '0;
    else     r_flags <= (i_clr ? flags_t'('0) : r_flags) | i_set;
  end

  assign o_flags = r_flags;
endmodule

// File: rtl/spi_cmd_bridge.sv
// Decodes one command per received SPI word, pops samples / reports status /
// writes ctrl, and loads the response for shifting out in the next CS frame.
module spi_cmd_bridge
  import spi_cmd_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int LEVEL_W = LEVEL_W_DEF,
  parameter int CTRL_W  = CTRL_W_DEF
) (
  input logic             clk,
  input logic             rst,
  spi_cmd_bridge_if.master bus
);
  state_e              r_state, w_next_state;
  logic [OPCODE_W-1:0] r_opcode;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [WORD_W-1:0]   r_resp, r_tx_data, w_resp, w_status;
  logic                r_popped;
  logic                w_accept, w_pop, w_ctrl_wr, w_tx_valid, w_clr;
  logic [OPCODE_W-1:0] w_rx_opcode;
  flags_t              w_set, w_flags;
  logic                w_unused;

  assign w_rx_opcode = bus.rx_data[WORD_W-1 -: OPCODE_W];

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_pop        = 1'b0;
    w_ctrl_wr    = 1'b0;
    w_clr        = 1'b0;
    w_tx_valid   = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.rx_valid) begin
        w_accept     = 1'b1;
        w_next_state = ST_DECODE;
      end
      ST_DECODE: begin
        w_pop        = (r_opcode == OP_READ_SAMPLE) && !bus.fifo_empty;
        w_ctrl_wr    = (r_opcode == OP_WRITE_CTRL);
        w_clr        = (r_opcode == OP_CLEAR_FLAGS);
        w_next_state = ST_FETCH;
      end
      ST_FETCH: w_next_state = ST_LOAD;
      ST_LOAD: begin
        w_tx_valid   = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ctrl is loaded with the command latch so it is already new during DECODE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opcode <= '0;
      r_ctrl   <= '0;
    end else if (w_accept) begin
      r_opcode <= w_rx_opcode;
      if (w_rx_opcode == OP_WRITE_CTRL) r_ctrl <= bus.rx_data[CTRL_W-1:0];
    end
  end

  assign w_set = '{
    overflow:  bus.fifo_overflow,
    underflow: (r_state == ST_DECODE) && (r_opcode == OP_READ_SAMPLE) && bus.fifo_empty,
    drop:      bus.rx_valid && (r_state != ST_IDLE)
  };

  sticky_flags u_flags (
    .clk     (clk),
    .rst     (rst),
    .i_set   (w_set),
    .i_clr   (w_clr),
    .o_flags (w_flags)
  );

  always_comb begin
    w_status                          = '0;
    w_status[LEVEL_W-1:0]             = bus.fifo_level;
    w_status[WORD_W-STAT_OVF_OFS]     = w_flags.overflow;
    w_status[WORD_W-STAT_UDF_OFS]     = w_flags.underflow;
    w_status[WORD_W-STAT_DROP_OFS]    = w_flags.drop;
    w_status[WORD_W-STAT_CAPEN_OFS]   = r_ctrl[0];
  end

  always_comb begin
    w_resp = '0;
    case (r_opcode)
      OP_NOP, OP_READ_SAMPLE:         w_resp = '0;
      OP_READ_STATUS, OP_CLEAR_FLAGS: w_resp = w_status;
      OP_WRITE_CTRL:                  w_resp = WORD_W'(r_ctrl);
      default:                        w_resp = ERR_RESP[WORD_W-1:0];
    endcase
  end

  // Status is captured in DECODE, before the clear lands at the end of it.
  // NOTE: r_resp/r_popped are always written in DECODE before use, but are
  // still reset so the datapath never carries X after a mid-command reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp   <= '0;
      r_popped <= 1'b0;
    end else if (r_state == ST_DECODE) begin
      r_resp   <= w_resp;
      r_popped <= w_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                     r_tx_data <= '0;
    else if (r_state == ST_FETCH) r_tx_data <= r_popped ? bus.fifo_rd_data : r_resp;
  end

  // Strobes are masked by rst so a reset mid-command issues no pop or load.
  assign bus.fifo_rd_en = w_pop & ~rst;
  assign bus.ctrl_wr    = w_ctrl_wr & ~rst;
  assign bus.tx_valid   = w_tx_valid & ~rst;
  assign bus.tx_data    = r_tx_data;
  assign bus.ctrl       = r_ctrl;

  // spi_idle carries no function here: frames without rx_valid are ignored.
  assign w_unused = &{1'b0, bus.spi_idle, bus.rx_data};
endmodule
